muladd_feeder: RTL and testbench

- Upstream stage for the muladd dot-product kernel.
- Accepts a stream of (a,b) operand pairs, stores SIZE pairs in two local ROM-style buffers, and starts the kernel with an ap_ctrl_hs handshake.
- Serves the kernel's a/b BRAM read ports with 1-cycle latency.
- Captures ap_return on ap_done and presents it downstream on a valid/ready result port.

---
 rtl/muladd_pkg.sv | 17 +
 rtl/muladd_feeder_buf.sv | 43 ++++
 rtl/muladd_feeder.sv | 169 ++++++++++++++++
 tb/tb_muladd_feeder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// muladd_pkg: shared definitions for the muladd feeder.
//   DEF_SIZE / DEF_DW / DEF_AW : default frame length, data width, address width
//   feeder_state_t             : feeder control states
package muladd_pkg;

  localparam int DEF_SIZE = 16;
  localparam int DEF_DW   = 32;
  localparam int DEF_AW   = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    OUT   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/muladd_feeder_buf.sv
// muladd_feeder_buf: SIZE x DW operand buffer, one write port, one registered
// read port (1-cycle latency, kernel BRAM style).
//   i_clk, i_rst_n     : clock, synchronous active-low reset (read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr       : read enable / address; out-of-range address reads 0
//   o_rdata            : registered read data, holds when i_re=0
module muladd_feeder_buf #(
  parameter int SIZE = 16,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam logic [AW:0] LIMIT = (AW+1)'(SIZE);

  // Storage is never cleared: a new frame always overwrites every entry
  // before the kernel is started.
  logic [DW-1:0] r_mem [SIZE];
  logic [DW-1:0] r_rdata;
  logic          w_in_range;

  assign w_in_range = ({1'b0, i_raddr} < LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= w_in_range ? r_mem[i_raddr] : '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/muladd_feeder.sv
// muladd_feeder: collects SIZE (a,b) operand pairs, starts the muladd kernel
// through ap_ctrl_hs, serves the kernel's a/b read ports and returns the
// kernel result on a valid/ready port.
//   ap_clk, ap_rst_n              : clock, synchronous active-low reset
//   s_valid/s_ready/s_a/s_b       : operand pair input stream
//   k_ap_start/ready/done/idle    : kernel control handshake
//   k_a_*, k_b_*                  : kernel buffer read ports (1-cycle latency)
//   k_ap_return                   : kernel result
//   m_valid/m_ready/m_data        : result output
//   mismatch                      : sticky self-check flag
// Build option: define MULADD_FEEDER_SELFCHECK_EN to accumulate sum(a*b)
// during LOAD and flag a kernel result that disagrees; otherwise mismatch=0.
module muladd_feeder
  import muladd_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_a,
  input  logic [DW-1:0] s_b,
  output logic          k_ap_start,
  input  logic          k_ap_ready,
  input  logic          k_ap_done,
  input  logic          k_ap_idle,
  input  logic [AW-1:0] k_a_address0,
  input  logic          k_a_ce0,
  output logic [DW-1:0] k_a_q0,
  input  logic [AW-1:0] k_b_address0,
  input  logic          k_b_ce0,
  output logic [DW-1:0] k_b_q0,
  input  logic [DW-1:0] k_ap_return,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          mismatch
);

  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

  feeder_state_t r_state;
  logic [AW-1:0] r_wr_ptr;
  logic          r_s_ready;
  logic          r_start;
  logic          r_m_valid;
  logic [DW-1:0] r_m_data;

  logic w_accept;
  logic w_capture;
  logic w_unused;

  // Kernel status is informational only.
  assign w_unused = k_ap_idle;

  assign w_accept  = (r_state == LOAD) && s_valid && r_s_ready;
  // Result capture covers both the normal RUN path and the case where the
  // kernel finishes in the same cycle it accepts start.
  assign w_capture = ((r_state == START) && k_ap_ready && k_ap_done) ||
                     ((r_state == RUN) && k_ap_done);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state   <= LOAD;
      r_wr_ptr  <= '0;
      r_s_ready <= 1'b0;
      r_start   <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            if (r_wr_ptr == LAST) begin
              r_wr_ptr  <= '0;
              r_s_ready <= 1'b0;
              r_start   <= 1'b1;
              r_state   <= START;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        START: begin
          if (k_ap_ready) begin
            r_start <= 1'b0;
            if (k_ap_done) begin
              r_m_data  <= k_ap_return;
              r_m_valid <= 1'b1;
              r_state   <= OUT;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (k_ap_done) begin
            r_m_data  <= k_ap_return;
            r_m_valid <= 1'b1;
            r_state   <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`ifdef MULADD_FEEDER_SELFCHECK_EN
  logic [DW-1:0] r_acc;
  logic          r_mismatch;
  logic [DW-1:0] w_prod;

  assign w_prod = s_a * s_b;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_acc      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      // First pair of a frame restarts the sum.
      if (w_accept) r_acc <= (r_wr_ptr == '0) ? w_prod : r_acc + w_prod;
      if (w_capture && (k_ap_return != r_acc)) r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`else
  assign mismatch = 1'b0;
`endif

  muladd_feeder_buf #(.SIZE(SIZE), .DW(DW), .AW(AW)) u_buf_a (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (s_a),
    .i_re    (k_a_ce0),
    .i_raddr (k_a_address0),
    .o_rdata (k_a_q0)
  );

  muladd_feeder_buf #(.SIZE(SIZE), .DW(DW), .AW(AW)) u_buf_b (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (s_b),
    .i_re    (k_b_ce0),
    .i_raddr (k_b_address0),
    .o_rdata (k_b_q0)
  );

  assign s_ready    = r_s_ready;
  assign k_ap_start = r_start;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;

endmodule

// File: tb/tb_muladd_feeder.sv
module tb_muladd_feeder;

  localparam int DW = 32;
  localparam int AW = 4;
`ifdef MULADD_FEEDER_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic          ap_rst_n;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_a, s_b;
  logic          k_ap_start, k_ap_ready, k_ap_done, k_ap_idle;
  logic [AW-1:0] k_a_address0, k_b_address0;
  logic          k_a_ce0, k_b_ce0;
  logic [DW-1:0] k_a_q0, k_b_q0, k_ap_return;
  logic          m_valid, m_ready, mismatch;
  logic [DW-1:0] m_data;

  // Second instance with SIZE=12 for the out-of-range read case.
  logic          t_s_valid, t_s_ready, t_k_ap_start, t_m_valid, t_mismatch;
  logic [DW-1:0] t_s_a, t_s_b, t_k_a_q0, t_k_b_q0, t_m_data;
  logic [AW-1:0] t_k_a_address0;
  logic          t_k_a_ce0;

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  logic [DW-1:0] va [16];
  logic [DW-1:0] vb [16];
  logic [DW-1:0] sum;

  muladd_feeder #(.SIZE(16), .DW(DW), .AW(AW)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done),
    .k_ap_idle(k_ap_idle),
    .k_a_address0(k_a_address0), .k_a_ce0(k_a_ce0), .k_a_q0(k_a_q0),
    .k_b_address0(k_b_address0), .k_b_ce0(k_b_ce0), .k_b_q0(k_b_q0),
    .k_ap_return(k_ap_return),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .mismatch(mismatch)
  );

  muladd_feeder #(.SIZE(12), .DW(DW), .AW(AW)) u_dut12 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(t_s_valid), .s_ready(t_s_ready), .s_a(t_s_a), .s_b(t_s_b),
    .k_ap_start(t_k_ap_start), .k_ap_ready(1'b0), .k_ap_done(1'b0),
    .k_ap_idle(1'b1),
    .k_a_address0(t_k_a_address0), .k_a_ce0(t_k_a_ce0), .k_a_q0(t_k_a_q0),
    .k_b_address0(4'd0), .k_b_ce0(1'b0), .k_b_q0(t_k_b_q0),
    .k_ap_return(32'd0),
    .m_valid(t_m_valid), .m_ready(1'b1), .m_data(t_m_data), .mismatch(t_mismatch)
  );

  always @(posedge ap_clk) if (k_ap_start === 1'b1) start_cyc++;

  task automatic tick;
    @(posedge ap_clk); #1;
  endtask

  // Streams va/vb into the main DUT, honouring s_ready with a bounded wait.
  task automatic load_frame;
    for (int i = 0; i < 16; i++) begin
      int n;
      s_a = va[i]; s_b = vb[i]; s_valid = 1'b1;
      n = 0;
      while (s_ready !== 1'b1 && n < 50) begin tick; n++; end
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL load_wait: s_ready=%b required 1 (pair %0d)", s_ready, i);
      end
      tick;
    end
    s_valid = 1'b0;
  endtask

  // Behavioural kernel: accept start, read all words, return sum + adj.
  task automatic kernel_run(input logic [DW-1:0] adj, output logic [DW-1:0] res);
    logic [DW-1:0] acc;
    checks++;
    if (k_ap_start !== 1'b1) begin
      errors++; $display("FAIL start_high: k_ap_start=%b required 1", k_ap_start);
    end
    k_ap_ready = 1'b1; tick; k_ap_ready = 1'b0;
    checks++;
    if (k_ap_start !== 1'b0) begin
      errors++; $display("FAIL start_drop: k_ap_start=%b required 0", k_ap_start);
    end
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      k_a_address0 = AW'(i); k_b_address0 = AW'(15 - i);
      k_a_ce0 = 1'b1; k_b_ce0 = 1'b1;
      tick;
      checks++;
      if (k_a_q0 !== va[i] || k_b_q0 !== vb[15-i]) begin
        errors++;
        $display("FAIL read_%0d: a_q0=%h b_q0=%h required %h %h",
                 i, k_a_q0, k_b_q0, va[i], vb[15-i]);
      end
      acc = acc + va[i] * vb[i];
    end
    k_a_ce0 = 1'b0; k_b_ce0 = 1'b0;
    k_ap_return = acc + adj; k_ap_done = 1'b1; tick; k_ap_done = 1'b0;
    res = acc;
  endtask

  task automatic set_ramp;
    for (int i = 0; i < 16; i++) begin va[i] = 32'(i); vb[i] = 32'(i + 1); end
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0; tick; tick; tick;
    checks++;
    if (s_ready !== 1'b0 || k_ap_start !== 1'b0 || m_valid !== 1'b0 ||
        m_data !== 32'd0 || k_a_q0 !== 32'd0 || k_b_q0 !== 32'd0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b start=%b mv=%b md=%h qa=%h qb=%h mm=%b required all 0",
               s_ready, k_ap_start, m_valid, m_data, k_a_q0, k_b_q0, mismatch);
    end
    ap_rst_n = 1'b1; tick; tick;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: s_ready=%b required 1", s_ready);
    end
  endtask

  task automatic test_basic;
    set_ramp; m_ready = 1'b1; start_cyc = 0;
    load_frame;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL basic_sready_start: s_ready=%b required 0", s_ready);
    end
    kernel_run(32'd0, sum);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h0000_0550) begin
      errors++; $display("FAIL basic_result: m_valid=%b m_data=%h required 1 00000550", m_valid, m_data);
    end
    tick;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || mismatch !== 1'b0) begin
      errors++; $display("FAIL basic_handshake: mv=%b rdy=%b mm=%b required 0 1 0", m_valid, s_ready, mismatch);
    end
    checks++;
    if (start_cyc !== 1) begin
      errors++; $display("FAIL basic_start_pulse: cycles=%0d required 1", start_cyc);
    end
    // ce0 low: read data must hold the last word read (a[15]).
    k_a_address0 = 4'd3; k_a_ce0 = 1'b0; tick;
    checks++;
    if (k_a_q0 !== 32'd15) begin
      errors++; $display("FAIL read_hold: k_a_q0=%h required 0000000f", k_a_q0);
    end
  endtask

  task automatic test_backpressure;
    set_ramp; m_ready = 1'b0;
    load_frame;
    kernel_run(32'd0, sum);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'h550 || s_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: mv=%b md=%h rdy=%b required 1 550 0", c, m_valid, m_data, s_ready);
      end
      tick;
    end
    m_ready = 1'b1; tick;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: mv=%b rdy=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_same_cycle;
    set_ramp; m_ready = 1'b1;
    load_frame;
    checks++;
    if (k_ap_start !== 1'b1) begin
      errors++; $display("FAIL sc_start: k_ap_start=%b required 1", k_ap_start);
    end
    k_ap_ready = 1'b1; k_ap_done = 1'b1; k_ap_return = 32'hDEAD_BEEF;
    tick;
    k_ap_ready = 1'b0; k_ap_done = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hDEAD_BEEF || k_ap_start !== 1'b0) begin
      errors++; $display("FAIL sc_result: mv=%b md=%h start=%b required 1 deadbeef 0", m_valid, m_data, k_ap_start);
    end
    checks++;
    if (mismatch !== SC) begin
      errors++; $display("FAIL sc_mismatch: mismatch=%b required %b", mismatch, SC);
    end
    tick;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL sc_handshake: mv=%b rdy=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    set_ramp; m_ready = 1'b1;
    load_frame;
    k_ap_ready = 1'b1; tick; k_ap_ready = 1'b0;
    k_a_address0 = 4'd2; k_a_ce0 = 1'b1; tick; k_a_ce0 = 1'b0;
    ap_rst_n = 1'b0; tick;
    checks++;
    if (k_ap_start !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0 ||
        k_a_q0 !== 32'd0 || m_data !== 32'd0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL rst_run: start=%b mv=%b rdy=%b qa=%h md=%h mm=%b required all 0",
               k_ap_start, m_valid, s_ready, k_a_q0, m_data, mismatch);
    end
    ap_rst_n = 1'b1;
    k_ap_done = 1'b1; k_ap_return = 32'h0000_1234; tick; k_ap_done = 1'b0;
    tick;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'd0) begin
      errors++; $display("FAIL stale_done: mv=%b md=%h required 0 0", m_valid, m_data);
    end
    for (int i = 0; i < 16; i++) begin va[i] = 32'd1; vb[i] = 32'd1; end
    load_frame;
    kernel_run(32'd0, sum);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h0000_0010) begin
      errors++; $display("FAIL ones_result: mv=%b md=%h required 1 00000010", m_valid, m_data);
    end
    tick;
    checks++;
    if (mismatch !== 1'b0) begin
      errors++; $display("FAIL ones_mismatch: mismatch=%b required 0", mismatch);
    end
  endtask

  task automatic test_out_of_range;
    for (int i = 0; i < 12; i++) begin
      int n;
      t_s_a = 32'h100 + 32'(i); t_s_b = 32'h200 + 32'(i); t_s_valid = 1'b1;
      n = 0;
      while (t_s_ready !== 1'b1 && n < 50) begin tick; n++; end
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL oor_load_wait: s_ready=%b required 1", t_s_ready);
      end
      tick;
    end
    t_s_valid = 1'b0;
    checks++;
    if (t_k_ap_start !== 1'b1) begin
      errors++; $display("FAIL oor_start: k_ap_start=%b required 1", t_k_ap_start);
    end
    t_k_a_address0 = 4'd11; t_k_a_ce0 = 1'b1; tick;
    checks++;
    if (t_k_a_q0 !== 32'h10B) begin
      errors++; $display("FAIL oor_last_word: k_a_q0=%h required 0000010b", t_k_a_q0);
    end
    t_k_a_address0 = 4'hF; tick;
    checks++;
    if (t_k_a_q0 !== 32'd0) begin
      errors++; $display("FAIL oor_addr_f: k_a_q0=%h required 0", t_k_a_q0);
    end
    t_k_a_address0 = 4'd0; tick;
    t_k_a_address0 = 4'd12; tick;
    checks++;
    if (t_k_a_q0 !== 32'd0) begin
      errors++; $display("FAIL oor_addr_12: k_a_q0=%h required 0", t_k_a_q0);
    end
    t_k_a_ce0 = 1'b0;
  endtask

  task automatic test_selfcheck;
    set_ramp; m_ready = 1'b1;
    load_frame;
    kernel_run(32'd1, sum);
    checks++;
    if (m_data !== 32'h551 || mismatch !== SC) begin
      errors++; $display("FAIL selfcheck_bad: md=%h mm=%b required 551 %b", m_data, mismatch, SC);
    end
    tick;
    load_frame;
    kernel_run(32'd0, sum);
    tick;
    checks++;
    if (mismatch !== SC) begin
      errors++; $display("FAIL selfcheck_sticky: mismatch=%b required %b", mismatch, SC);
    end
  endtask

  initial begin
    s_valid = 0; s_a = 0; s_b = 0;
    k_ap_ready = 0; k_ap_done = 0; k_ap_idle = 1; k_ap_return = 0;
    k_a_address0 = 0; k_b_address0 = 0; k_a_ce0 = 0; k_b_ce0 = 0;
    m_ready = 1;
    t_s_valid = 0; t_s_a = 0; t_s_b = 0; t_k_a_address0 = 0; t_k_a_ce0 = 0;
    ap_rst_n = 0;
    test_reset;
    test_basic;
    test_backpressure;
    test_same_cycle;
    test_reset_mid_run;
    test_out_of_range;
    test_selfcheck;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
